// File: rtl/aes_byte_io.sv
// Byte-serial loader/unloader around a fixed-latency AES cipher core.
// The key persists across blocks; each block needs 16 plaintext bytes and returns 16 ciphertext bytes.
module aes_byte_io #(
    parameter int CIPHER_LAT = 11
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic [7:0]   in_data,
    input  logic         in_is_key,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [7:0]   out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] Plain_Text,
    output logic [127:0] Key,
    input  logic [127:0] Cipher_Text,
    output logic         busy
);

    typedef enum logic [1:0] {LOAD, WAIT, UNLOAD} state_t;

    state_t       state, state_nx;
    logic [3:0]   pt_cnt, key_cnt, out_cnt;
    logic         pt_full, key_valid;
    logic         pt_full_nx, key_valid_nx;
    logic [7:0]   wait_cnt;
    logic [127:0] shift;
    logic         in_acc, pt_acc, key_acc, out_acc;

    // Key bytes stay acceptable once plaintext is full so a late key cannot deadlock.
    assign in_ready  = (state == LOAD) && (!pt_full || in_is_key);
    assign in_acc    = in_valid && in_ready;
    assign pt_acc    = in_acc && !in_is_key;
    assign key_acc   = in_acc && in_is_key;
    assign out_valid = (state == UNLOAD);
    assign out_acc   = out_valid && out_ready;
    assign out_data  = shift[127:120];
    assign busy      = (state != LOAD);

    // Flags as they will stand after this edge's accept; launch decision uses these.
    always_comb begin
        pt_full_nx   = pt_full || (pt_acc && (pt_cnt == 4'd15));
        key_valid_nx = key_valid;
        if (key_acc) begin
            if (key_cnt == 4'd15) begin
                key_valid_nx = 1'b1;
            end else if (key_cnt == 4'd0) begin
                key_valid_nx = 1'b0;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            LOAD:    if (pt_full_nx && key_valid_nx) state_nx = WAIT;
            WAIT:    if (wait_cnt == 8'd0) state_nx = UNLOAD;
            UNLOAD:  if (out_acc && (out_cnt == 4'd15)) state_nx = LOAD;
            default: state_nx = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= LOAD;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            Plain_Text <= '0;
            Key        <= '0;
            shift      <= '0;
            pt_cnt     <= '0;
            key_cnt    <= '0;
            out_cnt    <= '0;
            wait_cnt   <= '0;
            pt_full    <= 1'b0;
            key_valid  <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    // Byte n of a group lands in bits [127-8n -: 8]; {~cnt,3'b0} is that lsb.
                    if (pt_acc) begin
                        Plain_Text[{~pt_cnt, 3'b000} +: 8] <= in_data;
                        pt_cnt <= pt_cnt + 4'd1;
                    end
                    if (key_acc) begin
                        Key[{~key_cnt, 3'b000} +: 8] <= in_data;
                        key_cnt <= key_cnt + 4'd1;
                    end
                    pt_full   <= pt_full_nx;
                    key_valid <= key_valid_nx;
                    wait_cnt  <= 8'(CIPHER_LAT - 1);
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 8'd1;
                    if (wait_cnt == 8'd0) begin
                        shift   <= Cipher_Text;
                        out_cnt <= 4'd0;
                    end
                end
                UNLOAD: begin
                    if (out_acc) begin
                        shift   <= {shift[119:0], 8'h00};
                        out_cnt <= out_cnt + 4'd1;
                        if (out_cnt == 4'd15) begin
                            pt_cnt  <= 4'd0;
                            pt_full <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/aes_byte_io.md
# aes_byte_io

Byte-serial front/back end for the AES_cipher core. Assembles a 128-bit key and a 128-bit plaintext block from a byte stream, drives them onto the cipher's Plain_Text/Key inputs, and waits a fixed cipher latency. It then captures Cipher_Text and streams it out as 16 bytes. The key is retained across blocks, so only plaintext needs reloading per block.

## Interface
- CIPHER_LAT, 11: cycles from launch (first WAIT cycle) until Cipher_Text is valid; legal range 1..255.
- clk  in  1  system clock, all state on rising edge.
- nrst  in  1  asynchronous, active-low reset.
- in_data  in  8  input byte.
- in_is_key  in  1  1: byte belongs to key; 0: byte belongs to plaintext.
- in_valid  in  1  input byte valid.
- in_ready  out  1  input byte accepted when in_valid && in_ready (combinational).
- out_data  out  8  ciphertext byte.
- out_valid  out  1  ciphertext byte available.
- out_ready  in  1  consumer accepts byte when out_valid && out_ready.
- Plain_Text  out  128  registered plaintext to cipher.
- Key  out  128  registered key to cipher.
- Cipher_Text  in  128  cipher result.
- busy  out  1  state != LOAD.

## Operation
- States: LOAD, WAIT, UNLOAD. Reset state LOAD.
- Byte order: first byte of each 16-byte group lands in bits [127:120], last in [7:0]. Ciphertext leaves in the same order.
- LOAD:
  - Plaintext byte accepted: write Plain_Text at pt_cnt, pt_cnt++; pt_full is set on the 16th byte.
  - Key byte accepted: write Key at key_cnt, key_cnt++. The first byte of a key (key_cnt==0) clears key_valid. The 16th byte sets key_valid and wraps key_cnt to 0.
  - Key reload is allowed at any point in LOAD, including mid-plaintext. Plaintext progress is unaffected.
  - in_ready = (state==LOAD) && (!pt_full || in_is_key). This lets key bytes still load once plaintext is full, which prevents deadlock.
  - Go to WAIT at the first edge where pt_full && key_valid hold after the accept. This covers the final plaintext byte with the key already valid, or the final key byte with pt_full already set.
- WAIT:
  - Wait counter is loaded with CIPHER_LAT-1 on entry and decrements each cycle.
  - At count 0: Cipher_Text is latched into the output shift register, out_cnt=0, go to UNLOAD.
  - in_ready=0.
  - Plain_Text and Key hold constant.
- UNLOAD:
  - out_valid=1 and out_data=shift[127:120].
  - On accept: shift left 8, out_cnt++.
  - The 16th accept clears pt_cnt/pt_full, sets out_valid=0, and returns to LOAD.
  - Key and key_valid are kept.
  - out_data is stable while out_valid && !out_ready.
- Plain_Text/Key registers are never cleared by state transitions, only overwritten by new bytes or reset.

## Timing
- Reset (nrst low, asynchronous, any state): state=LOAD; Plain_Text=0, Key=0, shift=0, out_data=0, out_valid=0, busy=0; counters 0, pt_full=0, key_valid=0.
- in_ready=1 during and after reset, since it is combinational from LOAD.
- Reset mid-WAIT or mid-UNLOAD discards the block. No further out_valid until a full key and plaintext are reloaded.
- Final byte accepted at edge E: state=WAIT and busy=1 from E. Cipher_Text is sampled at edge E+CIPHER_LAT. out_valid=1 from that edge.
- Minimum output: 16 cycles with out_ready held high.
- End-to-end with continuous streams: 32 load cycles + CIPHER_LAT + 16 unload cycles.
- Key-only bytes arriving while pt_full && !key_valid are accepted at full rate.
- The first LOAD cycle after UNLOAD accepts bytes; there is no bubble.

## Test plan
- FIPS-197 App. B: 16 key bytes 2b 7e … 3c, then 16 plaintext bytes 32 43 … 34, with a cipher model of latency CIPHER_LAT=11 -> Key/Plain_Text match the 128-bit values; out bytes 39 25 84 1d 02 dc 09 fb dc 11 85 97 19 6a 0b 32; out_valid rises exactly 11 cycles after the last accept.
- Plaintext first, key second (pt_full before key_valid) -> in_ready=0 for in_is_key=0 and 1 for in_is_key=1; WAIT entered on the edge after the 16th key byte; same ciphertext.
- Second block without key reload (plaintext 00112233…eeff under the same key) -> launch after 16 plaintext bytes only; Key unchanged.
- out_ready toggling 1/0 every cycle during UNLOAD -> out_data held while stalled; 16 bytes in order, none duplicated or dropped; return to LOAD after byte 16.
- nrst pulsed low for 1 cycle mid-WAIT, then again mid-UNLOAD (byte 5) -> all outputs at reset values immediately; no out_valid until key and plaintext are fully reloaded.
- CIPHER_LAT=1 -> out_valid asserted on the edge after entering WAIT; Cipher_Text sampled that edge.
